fp_convert: RTL and testbench



---
 rtl/fp_convert_pkg.sv | 29 ++
 rtl/fp_convert_shift.sv | 65 ++++++
 rtl/fp_convert.sv | 139 +++++++++++++
 tb/tb_fp_convert.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/fp_convert_pkg.sv
// fp_convert_pkg: shared constants, the float class enum and the saturation
// constant helpers for the float-to-fixed converter.
//   FP_EXP_W / FP_MAN_W / FP_BIAS : IEEE-754 single-precision field layout
//   fp_class_e                    : ZERO, NORMAL, INF, NAN
//   max_pos / min_neg             : saturation limits for a given fixed width
package fp_convert_pkg;

    localparam int FP_EXP_W = 8;
    localparam int FP_MAN_W = 23;
    localparam int FP_BIAS  = 127;

    typedef enum logic [1:0] {
        ZERO   = 2'd0,
        NORMAL = 2'd1,
        INF    = 2'd2,
        NAN    = 2'd3
    } fp_class_e;

    // Largest positive two's-complement value of width fixed_w (low bits).
    function automatic logic [63:0] max_pos(input int fixed_w);
        return (64'd1 << (fixed_w - 1)) - 64'd1;
    endfunction

    // Most negative two's-complement value of width fixed_w (low bits).
    function automatic logic [63:0] min_neg(input int fixed_w);
        return ~64'd0 << (fixed_w - 1);
    endfunction

endpackage

// File: rtl/fp_convert_shift.sv
// fxp_shift_round: combinational barrel shifter that scales a 24-bit float
// significand into the fixed-point grid, rounds half away from zero on the
// magnitude and flags results that do not fit the signed range.
//   sig_i : significand with hidden bit (1.m)
//   exp_i : unbiased exponent (signed)
//   neg_i : sign of the value, selects the asymmetric magnitude limit
//   mag_o : low FIXED_WIDTH+1 bits of the exact rounded magnitude
//   ovf_o : rounded magnitude exceeds the representable range
module fxp_shift_round
    import fp_convert_pkg::*;
#(
    parameter int FRACTIONAL_WIDTH = 20,
    parameter int FIXED_WIDTH      = 24
) (
    input  logic               [FP_MAN_W:0]    sig_i,
    input  logic signed        [FP_EXP_W+1:0]  exp_i,
    input  logic                               neg_i,
    output logic               [FIXED_WIDTH:0] mag_o,
    output logic                               ovf_o
);

    localparam int SIG_W   = FP_MAN_W + 1;
    // Wide enough to hold the significand after the largest clamped left
    // shift, so overflow can be judged on the exact value.
    localparam int WIDE_W  = SIG_W + FIXED_WIDTH + 1;
    localparam int LSH_MAX = FIXED_WIDTH + 1;
    localparam int RSH_MAX = SIG_W + 1;

    // Half-away rounding on a magnitude only needs the guard bit: adding it
    // is floor(x + 0.5), and bits below the guard cannot change the outcome.
    function automatic logic [SIG_W:0] round_half_away(input logic [SIG_W:0] ext);
        return {1'b0, ext[SIG_W:1]} + {{SIG_W{1'b0}}, ext[0]};
    endfunction

    int                  sh;
    int                  lsh;
    int                  rsh;
    logic [SIG_W:0]      ext;
    logic [WIDE_W-1:0]   wide;
    logic [WIDE_W-1:0]   limit;

    always_comb begin
        lsh  = 0;
        rsh  = 0;
        ext  = '0;
        wide = '0;
        sh   = int'(exp_i) + FRACTIONAL_WIDTH - FP_MAN_W;
        if (sh >= 0) begin
            // Shifts beyond LSH_MAX overflow anyway and leave the low bits
            // zero, exactly as the unclamped shift would.
            lsh  = (sh > LSH_MAX) ? LSH_MAX : sh;
            wide = WIDE_W'(sig_i) << lsh;
        end else begin
            rsh  = (-sh > RSH_MAX) ? RSH_MAX : -sh;
            ext  = {sig_i, 1'b0} >> rsh;
            wide = WIDE_W'(round_half_away(ext));
        end
        // A negative value may reach one LSB further than a positive one.
        limit = neg_i ? WIDE_W'(max_pos(FIXED_WIDTH)) + WIDE_W'(1)
                      : WIDE_W'(max_pos(FIXED_WIDTH));
        ovf_o = (wide > limit);
        mag_o = wide[FIXED_WIDTH:0];
    end

endmodule

// File: rtl/fp_convert.sv
// fp_convert: three-stage IEEE-754 single to signed Q(INTEGER_WIDTH).(FRACTIONAL_WIDTH)
// converter feeding the CORDIC fixed-point datapath. Latency is three enabled
// clock edges; one conversion accepted per enabled cycle.
//   clk    : rising-edge clock
//   rst    : synchronous active-high reset, priority over clk_en
//   clk_en : advances every pipeline stage
//   dataa  : IEEE-754 single-precision input
//   result : signed fixed-point output, registered
//   ovf    : out of range, Inf or NaN, registered
// Build option: define FP_CONVERT_SATURATE_EN to clamp overflow and Inf to
// the signed limits; otherwise overflow wraps and Inf yields 0.
module fp_convert
    import fp_convert_pkg::*;
#(
    parameter  int INTEGER_WIDTH    = 4,
    parameter  int FRACTIONAL_WIDTH = 20,
    localparam int FIXED_WIDTH      = INTEGER_WIDTH + FRACTIONAL_WIDTH
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          clk_en,
    input  logic        [31:0]            dataa,
    output logic signed [FIXED_WIDTH-1:0] result,
    output logic                          ovf
);

    localparam logic [FIXED_WIDTH-1:0] MAX_POS = FIXED_WIDTH'(max_pos(FIXED_WIDTH));
    localparam logic [FIXED_WIDTH-1:0] MIN_NEG = FIXED_WIDTH'(min_neg(FIXED_WIDTH));

    // Stage 1: field decode and classification
    logic                        sign_d;
    fp_class_e                   cls_d;
    logic signed [FP_EXP_W+1:0]  exp_d;
    logic        [FP_MAN_W:0]    sig_d;

    logic                        sign_p1_q;
    fp_class_e                   cls_p1_q;
    logic signed [FP_EXP_W+1:0]  exp_p1_q;
    logic        [FP_MAN_W:0]    sig_p1_q;

    always_comb begin
        sign_d = dataa[31];
        exp_d  = $signed({2'b00, dataa[30:23]}) - (FP_EXP_W+2)'(FP_BIAS);
        sig_d  = {1'b1, dataa[22:0]};
        if (dataa[30:23] == '0)
            cls_d = ZERO;
        else if (dataa[30:23] == '1)
            cls_d = (dataa[22:0] == '0) ? INF : NAN;
        else
            cls_d = NORMAL;
    end

    // Stage 2: scale, round, range check
    logic [FIXED_WIDTH:0] sh_mag;
    logic                 sh_ovf;
    logic [FIXED_WIDTH:0] mag_d;
    logic                 ovf_p2_d;

    logic [FIXED_WIDTH:0] mag_p2_q;
    logic                 ovf_p2_q;
    logic                 sign_p2_q;
`ifdef FP_CONVERT_SATURATE_EN
    logic                 nan_p2_q;
`endif

    fxp_shift_round #(
        .FRACTIONAL_WIDTH (FRACTIONAL_WIDTH),
        .FIXED_WIDTH      (FIXED_WIDTH)
    ) u_shift_round (
        .sig_i (sig_p1_q),
        .exp_i (exp_p1_q),
        .neg_i (sign_p1_q),
        .mag_o (sh_mag),
        .ovf_o (sh_ovf)
    );

    // Inf and NaN carry a zero magnitude so the wrap build outputs 0 for them.
    always_comb begin
        mag_d    = '0;
        ovf_p2_d = 1'b0;
        case (cls_p1_q)
            NORMAL: begin
                mag_d    = sh_mag;
                ovf_p2_d = sh_ovf;
            end
            INF, NAN: ovf_p2_d = 1'b1;
            default: ;
        endcase
    end

    // Stage 3: sign application and saturation/wrap
    logic signed [FIXED_WIDTH-1:0] signed_val;
    logic signed [FIXED_WIDTH-1:0] result_d;

    always_comb begin
        signed_val = sign_p2_q ? -mag_p2_q[FIXED_WIDTH-1:0] : mag_p2_q[FIXED_WIDTH-1:0];
`ifdef FP_CONVERT_SATURATE_EN
        if (nan_p2_q)
            result_d = '0;
        else if (ovf_p2_q)
            result_d = sign_p2_q ? MIN_NEG : MAX_POS;
        else
            result_d = signed_val;
`else
        result_d = signed_val;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sign_p1_q <= 1'b0;
            cls_p1_q  <= ZERO;
            exp_p1_q  <= '0;
            sig_p1_q  <= '0;
            mag_p2_q  <= '0;
            ovf_p2_q  <= 1'b0;
            sign_p2_q <= 1'b0;
`ifdef FP_CONVERT_SATURATE_EN
            nan_p2_q  <= 1'b0;
`endif
            result    <= '0;
            ovf       <= 1'b0;
        end else if (clk_en) begin
            sign_p1_q <= sign_d;
            cls_p1_q  <= cls_d;
            exp_p1_q  <= exp_d;
            sig_p1_q  <= sig_d;
            mag_p2_q  <= mag_d;
            ovf_p2_q  <= ovf_p2_d;
            sign_p2_q <= sign_p1_q;
`ifdef FP_CONVERT_SATURATE_EN
            nan_p2_q  <= (cls_p1_q == NAN);
`endif
            result    <= result_d;
            ovf       <= ovf_p2_q;
        end
    end

endmodule

// File: tb/tb_fp_convert.sv
// tb_fp_convert: directed-vector bench for fp_convert with an arithmetic
// reference model tracked through a latency pipeline and literal checks.
module tb_fp_convert;

`ifdef FP_CONVERT_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        clk_en;
    logic [31:0] dataa;
    logic signed [23:0] result;
    logic        ovf;

    int checks   = 0;
    int failures = 0;
    bit chk_on   = 1'b0;

    fp_convert dut (
        .clk    (clk),
        .rst    (rst),
        .clk_en (clk_en),
        .dataa  (dataa),
        .result (result),
        .ovf    (ovf)
    );

    always #5 clk = ~clk;

    // Reference: value = sig * 2^(e-150), scaled by 2^20, rounded as floor(x+0.5).
    function automatic void fmodel(input logic [31:0] d, output logic [23:0] r, output logic o);
        longint e;
        longint sig;
        longint k;
        longint mag;
        bit     s;
        bit     big;
        s   = d[31];
        e   = longint'(d[30:23]);
        sig = longint'(d[22:0]) | (64'sd1 << 23);
        big = 1'b0;
        mag = 0;
        r   = 24'd0;
        o   = 1'b0;
        if (e == 0) begin
            r = 24'd0;
            o = 1'b0;
        end else if (e == 255) begin
            o = 1'b1;
            if (d[22:0] != 0) r = 24'd0;
            else r = SAT ? (s ? 24'h800000 : 24'h7FFFFF) : 24'd0;
        end else begin
            k = e - 130;
            if (k >= 0) begin
                if (k >= 39) begin
                    big = 1'b1;
                    mag = 0;
                end else begin
                    mag = sig << k;
                end
            end else if (-k >= 40) begin
                mag = 0;
            end else begin
                mag = (sig + (64'sd1 << (-k - 1))) >>> (-k);
            end
            o = big || (s ? (mag > 64'sd8388608) : (mag > 64'sd8388607));
            if (o && SAT) r = s ? 24'h800000 : 24'h7FFFFF;
            else          r = s ? 24'(-mag) : 24'(mag);
        end
    endfunction

    logic [23:0] mr [3];
    logic        mo [3];
    initial begin
        for (int i = 0; i < 3; i++) begin
            mr[i] = '0;
            mo[i] = 1'b0;
        end
    end

    always @(posedge clk) begin : model_pipe
        logic [23:0] r_new;
        logic        o_new;
        fmodel(dataa, r_new, o_new);
        if (rst) begin
            for (int i = 0; i < 3; i++) begin
                mr[i] <= '0;
                mo[i] <= 1'b0;
            end
        end else if (clk_en) begin
            mr[0] <= r_new;  mo[0] <= o_new;
            mr[1] <= mr[0];  mo[1] <= mo[0];
            mr[2] <= mr[1];  mo[2] <= mo[1];
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            checks++;
            if (result !== mr[2] || ovf !== mo[2]) begin
                failures++;
                $display("FAIL pipe t=%0t result=%h ovf=%b required result=%h ovf=%b",
                         $time, result, ovf, mr[2], mo[2]);
            end
        end
    end

    task automatic step(input logic [31:0] d, input logic en, input logic r);
        dataa  = d;
        clk_en = en;
        rst    = r;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_lit(input string name, input logic [23:0] er, input logic eo);
        checks++;
        if (result !== er || ovf !== eo) begin
            failures++;
            $display("FAIL %s result=%h ovf=%b required result=%h ovf=%b", name, result, ovf, er, eo);
        end
    endtask

    task automatic conv(input string name, input logic [31:0] d,
                        input logic [23:0] er_sat, input logic [23:0] er_wrap, input logic eo);
        step(d, 1'b1, 1'b0);
        step(32'h0, 1'b1, 1'b0);
        step(32'h0, 1'b1, 1'b0);
        expect_lit(name, SAT ? er_sat : er_wrap, eo);
    endtask

    initial begin
        dataa  = 32'h0;
        clk_en = 1'b0;
        rst    = 1'b1;
        step(32'h3F800000, 1'b0, 1'b1);
        step(32'h3F800000, 1'b1, 1'b1);
        expect_lit("reset", 24'h000000, 1'b0);
        chk_on = 1'b1;

        conv("one",        32'h3F800000, 24'h100000, 24'h100000, 1'b0);
        conv("pi_over_4",  32'h3F490FDB, 24'h0C90FE, 24'h0C90FE, 1'b0);
        conv("neg_one",    32'hBF800000, 24'hF00000, 24'hF00000, 1'b0);
        conv("neg_eight",  32'hC1000000, 24'h800000, 24'h800000, 1'b0);
        conv("half",       32'h3F000000, 24'h080000, 24'h080000, 1'b0);
        conv("pos_eight",  32'h41000000, 24'h7FFFFF, 24'h800000, 1'b1);
        conv("below_neg8", 32'hC1000001, 24'h800000, 24'h7FFFFF, 1'b1);
        conv("round_carry",32'h40FFFFFF, 24'h7FFFFF, 24'h800000, 1'b1);
        conv("max_float",  32'h7F7FFFFF, 24'h7FFFFF, 24'h000000, 1'b1);
        conv("neg_inf",    32'hFF800000, 24'h800000, 24'h000000, 1'b1);
        conv("pos_inf",    32'h7F800000, 24'h7FFFFF, 24'h000000, 1'b1);
        conv("half_lsb",   32'h35000000, 24'h000001, 24'h000001, 1'b0);
        conv("neg_halflsb",32'hB5000000, 24'hFFFFFF, 24'hFFFFFF, 1'b0);
        conv("quarter_lsb",32'h34800000, 24'h000000, 24'h000000, 1'b0);
        conv("neg_zero",   32'h80000000, 24'h000000, 24'h000000, 1'b0);
        conv("denormal",   32'h00000001, 24'h000000, 24'h000000, 1'b0);
        conv("nan",        32'h7FC00000, 24'h000000, 24'h000000, 1'b1);

        // Two stalled cycles mid-flight delay the output by exactly two cycles.
        step(32'hBF800000, 1'b1, 1'b0);
        step(32'h3F800000, 1'b1, 1'b0);
        step(32'h0,        1'b0, 1'b0);
        step(32'h0,        1'b0, 1'b0);
        step(32'h0,        1'b1, 1'b0);
        expect_lit("stall_prev", 24'hF00000, 1'b0);
        step(32'h0,        1'b1, 1'b0);
        expect_lit("stall_one",  24'h100000, 1'b0);

        // Reset mid-stream (with clk_en low to show reset priority).
        step(32'h41000000, 1'b1, 1'b0);
        step(32'hBF800000, 1'b1, 1'b0);
        step(32'h3F800000, 1'b0, 1'b1);
        expect_lit("rst_flush", 24'h000000, 1'b0);
        step(32'h3F800000, 1'b1, 1'b0);
        expect_lit("no_leak_a", 24'h000000, 1'b0);
        step(32'h3F490FDB, 1'b1, 1'b0);
        expect_lit("no_leak_b", 24'h000000, 1'b0);
        step(32'hC1000000, 1'b1, 1'b0);
        expect_lit("resume_c",  24'h100000, 1'b0);
        step(32'h0,        1'b1, 1'b0);
        expect_lit("resume_d",  24'h0C90FE, 1'b0);
        step(32'h0,        1'b1, 1'b0);
        expect_lit("resume_e",  24'h800000, 1'b0);

        step(32'h0, 1'b1, 1'b0);
        chk_on = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
